// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port memory with a 1-cycle registered read.
// Grant is combinational (zero latency). A bounded-burst round-robin rule
// keeps either master from starving the other. Read-valid is registered and
// routed back to the master that issued the read.
module mem_arbiter #(
  parameter int AWIDTH    = 16,
  parameter int DWIDTH    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_re,
  input  logic              m0_we,
  input  logic [AWIDTH-2:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_wait,
  output logic              m0_rvalid,
  input  logic              m1_re,
  input  logic              m1_we,
  input  logic [AWIDTH-2:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_wait,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-2:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q;
  logic          owner_q;
  logic [CW-1:0] cnt_q;
  logic          m0_rvalid_q;
  logic          m1_rvalid_q;

  logic req0, req1;
  logic grant0, grant1;

  assign req0 = m0_re | m0_we;
  assign req1 = m1_re | m1_we;

  // Grant selection: a lone requester wins; on contention the owner keeps the
  // memory until its burst budget is spent. Nothing is granted while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      if (req0 && req1) begin
        if (cnt_q < BMAX) begin
          grant0 = ~owner_q;
          grant1 = owner_q;
        end else begin
          grant0 = owner_q;
          grant1 = ~owner_q;
        end
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Memory port mux; a simultaneous re+we is treated as a write only.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (grant1) begin
      mem_re    = m1_re & ~m1_we;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (grant0) begin
      mem_re = m0_re & ~m0_we;
      mem_we = m0_we;
    end
  end

  assign m0_wait   = req0 & ~grant0;
  assign m1_wait   = req1 & ~grant1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign rdata     = mem_rdata;

  // Ownership FSM, burst counter and read-return tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= grant0 & m0_re & ~m0_we;
      m1_rvalid_q <= grant1 & m1_re & ~m1_we;
      if (!(grant0 || grant1)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if ((grant1 == owner_q) && (state_q != IDLE)) begin
        if (cnt_q != BMAX) cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q   <= CW'(1);
        owner_q <= grant1;
        state_q <= grant1 ? OWN1 : OWN0;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory (1-cycle registered read, `re`/`we`, word-addressed, AWIDTH-1 address bits) between two bus masters.
  - Master 0 is the cpu.
  - Master 1 is a DMA/peripheral master.
- Grants one access per cycle, stalls the loser with a wait signal, and routes read-data valid back to the issuing master.
- Bounded-burst round-robin prevents either master starving the other.

Parameters:
- AWIDTH, 16: bus address width; address ports are AWIDTH-1 bits (word address).
- DWIDTH, 16: data width.
- BURST_MAX, 4: max consecutive grants to one master while the other is requesting (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_re  in  1  master 0 read request
- m0_we  in  1  master 0 write request
- m0_addr  in  AWIDTH-1  master 0 word address
- m0_wdata  in  DWIDTH  master 0 write data
- m0_wait  out  1  master 0 stalled this cycle; hold request stable
- m0_rvalid  out  1  read data for master 0 valid this cycle
- m1_re, m1_we, m1_addr, m1_wdata, m1_wait, m1_rvalid: same as master 0, for master 1
- rdata  out  DWIDTH  read data to both masters (= mem_rdata)
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  AWIDTH-1  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data, valid the cycle after mem_re is sampled

Behaviour:
- Request: reqN = mN_re | mN_we. If mN_re and mN_we are both high, the access is a write only: mem_re=0, no rvalid.
- State:
  - owner (1 bit): 0=m0, 1=m1, last-granted master.
  - cnt (clog2(BURST_MAX)+1 bits): consecutive grants to owner.
  - Arbitration FSM states: IDLE, OWN0, OWN1.
- Grant is combinational from req0, req1, owner and cnt, and is evaluated every cycle:
  - neither request -> no grant; next state IDLE, cnt<=0, owner unchanged.
  - one request -> grant that master.
  - both requests -> grant owner if cnt<BURST_MAX, else grant the other master.
  - Granting a master equal to owner with the previous state not IDLE -> cnt<=cnt+1, saturating at BURST_MAX.
  - Otherwise (switch, or grant out of IDLE) -> cnt<=1, owner<=granted, state OWNx.
- Memory outputs are a combinational mux of the granted master's inputs. With no grant, mem_re=mem_we=0, and mem_addr/mem_wdata hold master 0's values.
- mN_wait = reqN & ~grantN (combinational). Masters keep re/we/addr/wdata stable while wait=1. A stalled master must not drop its request.
- Read return:
  - mN_rvalid is registered: high exactly one cycle after a granted read by master N, otherwise 0.
  - rdata is passed through combinationally from mem_rdata.
  - Back-to-back reads from alternating masters produce alternating rvalid with no bubbles.
- Throughput: one access per cycle, zero arbitration latency; the granted master proceeds in the same cycle.
- Reset (rst=0, asynchronous):
  - owner=0, cnt=0, state IDLE, m0_rvalid=m1_rvalid=0.
  - While rst is low: mem_re=mem_we=0, mN_wait=reqN.
  - An access in flight at reset assertion is dropped and its rvalid is not generated.
  - Deassertion takes effect at the next clk edge.
- Simultaneous events:
  - A request arriving in the same cycle another master's burst limit is hit is granted that cycle.
  - A write and a read from different masters in the same cycle are serialized by the grant rule; there is never a memory collision.

Test Plan:
- Reset then idle: rst low 2 cycles -> mem_re=mem_we=0, rvalids 0, both waits 0 with no requests; rst asynchronous mid-cycle clears m0_rvalid immediately.
- m0 alone reads addr 0x0010 (mem holds 0x1234) -> mem_re=1, mem_addr=0x0010 same cycle; m0_rvalid=1 and rdata=0x1234 next cycle; m0_wait=0 throughout.
- m0 and m1 both read continuously from reset, BURST_MAX=4 -> grants 0,0,0,0,1,1,1,1,0...; loser's wait=1 on exactly the cycles not granted; rvalid follows each grant by 1 cycle.
- m1 write 0xBEEF to 0x0020 while m0 reads 0x0020 in the same cycle, owner=0, cnt=0 -> m0 read first returns old value; m1 write next cycle; m0 re-read returns 0xBEEF.
- m0_re=m0_we=1 with wdata 0x5555 -> write performed, mem_re=0, no m0_rvalid.
- Burst with gap: m0 requests 3 cycles, idles 1, requests 3 more while m1 requests continuously -> cnt resets on idle cycle; m1 granted during m0 idle, then alternation per BURST_MAX rule.
